// File: rtl/ycbcr2rgb.sv
// rtl/ycbcr2rgb.sv - BT.601 studio-range YCbCr to full-range RGB, 4-stage pipeline
//
// Ports:
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   in_y, in_cb, in_cr [7:0]   input sample
//   in_sof, in_eol             sideband, qualified by in_valid
//   in_valid / in_ready        input handshake (in_ready is combinational)
//   out_r, out_g, out_b [7:0]  registered RGB result
//   out_sof, out_eol           sideband aligned with the RGB result
//   out_valid / out_ready      output handshake
module ycbcr2rgb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_y,
  input  logic [7:0] in_cb,
  input  logic [7:0] in_cr,
  input  logic       in_sof,
  input  logic       in_eol,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_r,
  output logic [7:0] out_g,
  output logic [7:0] out_b,
  output logic       out_sof,
  output logic       out_eol,
  output logic       out_valid,
  input  logic       out_ready
);

  // Whole pipeline moves as one: it advances whenever the output slot is
  // free or being drained this cycle, otherwise every stage holds.
  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  // Stage 1: offset-removed components
  logic              s1_v;
  logic [1:0]        s1_sb;  // {sof, eol}
  logic signed [9:0] s1_c, s1_d, s1_e;

  // Stage 2: products
  logic               s2_v;
  logic [1:0]         s2_sb;
  logic signed [19:0] s2_rc, s2_re, s2_gd, s2_ge, s2_bd;

  // Stage 3: rounded sums (+128 is the half-LSB for the later >>> 8)
  logic               s3_v;
  logic [1:0]         s3_sb;
  logic signed [19:0] s3_r, s3_g, s3_b;

  function automatic logic signed [19:0] sx20(input logic signed [9:0] v);
    return {{10{v[9]}}, v};
  endfunction

  // (v >>> 8) clamped to 0..255: negative -> 0, v >= 256*256 -> 255
  function automatic logic [7:0] clamp8(input logic signed [19:0] v);
    if (v < 20'sd0)
      return 8'd0;
    else if (v > 20'sd65535)
      return 8'hff;
    else
      return v[15:8];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v  <= 1'b0;
      s1_sb <= 2'b00;
      s1_c  <= '0;
      s1_d  <= '0;
      s1_e  <= '0;
    end else if (en) begin
      // Bubble data is loaded too; only the valid bit matters for it.
      s1_v  <= in_valid;
      s1_sb <= {in_sof, in_eol};
      s1_c  <= {2'b00, in_y}  - 10'd16;
      s1_d  <= {2'b00, in_cb} - 10'd128;
      s1_e  <= {2'b00, in_cr} - 10'd128;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v  <= 1'b0;
      s2_sb <= 2'b00;
      s2_rc <= '0;
      s2_re <= '0;
      s2_gd <= '0;
      s2_ge <= '0;
      s2_bd <= '0;
    end else if (en) begin
      s2_v  <= s1_v;
      s2_sb <= s1_sb;
      s2_rc <= sx20(s1_c) * 20'sd298;
      s2_re <= sx20(s1_e) * 20'sd409;
      s2_gd <= sx20(s1_d) * 20'sd100;
      s2_ge <= sx20(s1_e) * 20'sd208;
      s2_bd <= sx20(s1_d) * 20'sd516;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_v  <= 1'b0;
      s3_sb <= 2'b00;
      s3_r  <= '0;
      s3_g  <= '0;
      s3_b  <= '0;
    end else if (en) begin
      s3_v  <= s2_v;
      s3_sb <= s2_sb;
      s3_r  <= s2_rc + s2_re + 20'sd128;
      s3_g  <= s2_rc - s2_gd - s2_ge + 20'sd128;
      s3_b  <= s2_rc + s2_bd + 20'sd128;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_r     <= 8'd0;
      out_g     <= 8'd0;
      out_b     <= 8'd0;
    end else if (en) begin
      out_valid <= s3_v;
      out_sof   <= s3_sb[1];
      out_eol   <= s3_sb[0];
      out_r     <= clamp8(s3_r);
      out_g     <= clamp8(s3_g);
      out_b     <= clamp8(s3_b);
    end
  end

endmodule

// File: tb/tb_ycbcr2rgb.sv
// tb/tb_ycbcr2rgb.sv - scoreboard bench for ycbcr2rgb
module tb_ycbcr2rgb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_y = 8'd0, in_cb = 8'd0, in_cr = 8'd0;
  logic       in_sof = 1'b0, in_eol = 1'b0, in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_r, out_g, out_b;
  logic       out_sof, out_eol, out_valid;
  logic       out_ready = 1'b1;

  ycbcr2rgb dut (
    .clk(clk), .rst_n(rst_n),
    .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr),
    .in_sof(in_sof), .in_eol(in_eol), .in_valid(in_valid), .in_ready(in_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_sof(out_sof), .out_eol(out_eol), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r, g, b;
    int sof, eol;
    int stamp;
  } exp_t;

  exp_t sb[$];
  exp_t ovr;
  bit   ovr_on = 1'b0;
  bit   lat_on = 1'b0;
  int   bp_mode = 0;   // 0: out_ready = bp_val, 1: random 50%
  bit   bp_val = 1'b1;
  int   total = 0, bad = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  // Reference: the conversion equations evaluated in plain integer arithmetic.
  function automatic exp_t model(input int y, input int cb, input int cr);
    exp_t e;
    int c, d, ee;
    c  = y - 16;
    d  = cb - 128;
    ee = cr - 128;
    e.r = clamp((298*c + 409*ee + 128) >>> 8);
    e.g = clamp((298*c - 100*d - 208*ee + 128) >>> 8);
    e.b = clamp((298*c + 516*d + 128) >>> 8);
    e.sof = 0; e.eol = 0; e.stamp = 0;
    return e;
  endfunction

  // Scoreboard push: a beat is accepted at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && in_valid && in_ready) begin
      if (ovr_on) begin
        e = ovr;
        ovr_on = 1'b0;
      end else begin
        e = model(int'(in_y), int'(in_cb), int'(in_cr));
      end
      e.sof   = int'(in_sof);
      e.eol   = int'(in_eol);
      e.stamp = cyc;
      sb.push_back(e);
    end
  end

  // Monitor: handshake rule, hold-while-stalled, ordering and data.
  bit       prev_stall = 1'b0;
  bit [25:0] held;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_rule", int'(in_ready), int'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_hold", int'({out_sof, out_eol, out_r, out_g, out_b}), int'(held));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rgb", int'({out_r, out_g, out_b}), (e.r << 16) | (e.g << 8) | e.b);
          chk("sof", int'(out_sof), e.sof);
          chk("eol", int'(out_eol), e.eol);
          if (lat_on) chk("latency", cyc - e.stamp, 4);
        end
      end
      prev_stall = out_valid && !out_ready;
      held = {out_sof, out_eol, out_r, out_g, out_b};
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_mode == 1) out_ready = 1'($urandom % 2);
    else              out_ready = bp_val;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] y, cb, cr, input logic sof, eol);
    in_y = y; in_cb = cb; in_cr = cr; in_sof = sof; in_eol = eol;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_exp(input logic [7:0] y, cb, cr, input int r, g, b);
    ovr.r = r; ovr.g = g; ovr.b = b;
    ovr_on = 1'b1;
    send(y, cb, cr, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int t = 0; t < 500; t++) begin
      if (sb.size() == 0 && !out_valid) return;
      tick();
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_rgb", int'({out_r, out_g, out_b}), 0);
    chk("rst_sideband", int'({out_sof, out_eol}), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed black/white and clamp corners, one at a time with exact latency.
    lat_on = 1'b1; bp_mode = 0; bp_val = 1'b1;
    send_exp(8'd16,  8'd128, 8'd128, 0, 0, 0);       drain();
    send_exp(8'd235, 8'd128, 8'd128, 255, 255, 255); drain();
    send_exp(8'd81,  8'd90,  8'd240, 255, 0, 0);     drain();
    send_exp(8'd255, 8'd255, 8'd255, 255, 125, 255); drain();
    send_exp(8'd0,   8'd0,   8'd0,   0, 135, 0);     drain();

    // Back-to-back streaming, 64 beats.
    for (int i = 0; i < 64; i++)
      send(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    drain();

    // One 8-beat line with sof/eol markers.
    for (int i = 0; i < 8; i++)
      send(8'($urandom), 8'($urandom), 8'($urandom), 1'(i == 0), 1'(i == 7));
    drain();

    // Random backpressure and random input gaps.
    lat_on = 1'b0; bp_mode = 1;
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      send(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom % 2), 1'($urandom % 2));
    end
    drain();

    // Reset with three beats in flight and output stalled.
    bp_mode = 0; bp_val = 1'b0;
    tick();
    for (int i = 0; i < 3; i++)
      send(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_rgb", int'({out_r, out_g, out_b}), 0);
    chk("midrst_sideband", int'({out_sof, out_eol}), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    bp_val = 1'b1;
    tick();
    chk("post_rst_in_ready", int'(in_ready), 1);
    lat_on = 1'b1;
    send_exp(8'd235, 8'd128, 8'd128, 255, 255, 255);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
